// File: rtl/inst_mem_loader.sv
// Instruction memory with a combinational fetch port and a byte-stream program loader.
// Latency: fetch is combinational; a load costs BPW+1 cycles per word plus one DONE cycle.
// Backpressure: byte_ready is high only in ASSEMBLE, so there is one bubble per word while it is written.
module inst_mem_loader #(
    parameter int    DATA_W    = 16,
    parameter int    ADDR_W    = 8,
    parameter int    BYTE_W    = 8,
    parameter string INIT_FILE = "instructions.data"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fetch_add,
    output logic [DATA_W-1:0] fetch_dout,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_count,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              load_busy,
    output logic              load_done
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BPW    = DATA_W / BYTE_W;
    localparam int BEAT_W = (BPW > 1) ? $clog2(BPW) : 1;

    // A word must split into whole beats, otherwise assembly would leave a ragged top slice.
    if (DATA_W % BYTE_W != 0) begin : g_bad_width
        $fatal(1, "inst_mem_loader: DATA_W must be a multiple of BYTE_W");
    end

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ASSEMBLE = 2'd1,
        S_WRITE    = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     r_words;
    logic [BEAT_W-1:0]   r_beat;
    logic [DATA_W-1:0]   r_asm;

    logic                w_beat_acc;
    logic                w_last_beat;
    logic [ADDR_W:0]     w_words_inc;
    logic [DATA_W-1:0]   w_asm_nxt;

    assign fetch_dout  = r_mem[fetch_add];
    assign w_beat_acc  = (r_state == S_ASSEMBLE) && byte_valid;
    assign w_last_beat = (r_beat == BEAT_W'(BPW - 1));
    assign w_words_inc = r_words + 1'b1;
    // Shifting left means the first beat of a word ends up in the top slice (big-endian).
    assign w_asm_nxt   = (r_asm << BYTE_W) | DATA_W'(byte_data);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; starts are honoured only in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (load_start) begin
                    w_state_nxt = (load_count == '0) ? S_DONE : S_ASSEMBLE;
                end
            end
            S_ASSEMBLE: begin
                if (w_beat_acc && w_last_beat) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_state_nxt = (w_words_inc == r_count) ? S_DONE : S_ASSEMBLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state only.
    always_comb begin
        byte_ready = (r_state == S_ASSEMBLE);
        load_busy  = (r_state != S_IDLE);
        load_done  = (r_state == S_DONE);
    end

    // Load datapath: address, word/beat counters and the assembly register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_count <= '0;
            r_words <= '0;
            r_beat  <= '0;
            r_asm   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (load_start) begin
                        r_addr  <= load_base;
                        r_count <= load_count;
                        r_words <= '0;
                        r_beat  <= '0;
                        r_asm   <= '0;
                    end
                end
                S_ASSEMBLE: begin
                    if (w_beat_acc) begin
                        r_asm  <= w_asm_nxt;
                        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
                    end
                end
                S_WRITE: begin
                    r_addr  <= r_addr + 1'b1;
                    r_words <= w_words_inc;
                end
                default: begin
                end
            endcase
        end
    end

    // Memory write port; a reset landing on a WRITE cycle suppresses that write.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_WRITE) begin
            r_mem[r_addr] <= r_asm;
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: load timing, wrap, gaps, zero count, reset and fetch bypass.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: byte_valid is driven by the bench and honoured only when byte_ready is high.
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  fetch_add;
    logic [15:0] fetch_dout;
    logic        load_start;
    logic [7:0]  load_base;
    logic [8:0]  load_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        load_busy;
    logic        load_done;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] model  [256];
    logic [7:0]  stream [512];

    inst_mem_loader #(
        .DATA_W   (16),
        .ADDR_W   (8),
        .BYTE_W   (8),
        .INIT_FILE("")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_add (fetch_add),
        .fetch_dout(fetch_dout),
        .load_start(load_start),
        .load_base (load_base),
        .load_count(load_count),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .byte_ready(byte_ready),
        .load_busy (load_busy),
        .load_done (load_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_mem(input string tag, input logic [7:0] a);
        fetch_add = a;
        #1;
        chk(tag, fetch_dout, model[a]);
    endtask

    // Runs one load from stream[0..nbytes-1]. Cycle 1 is the cycle after the start edge.
    // Returns on the first cycle after load_done drops (busy should already be low there).
    task automatic do_load(input logic [7:0] base, input logic [8:0] cnt, input int nbytes,
                           input bit gaps, input bit restart_mid,
                           input bit probe, input logic [15:0] probe_old, input logic [15:0] probe_new,
                           output int done_cyc, output int ndone);
        int  idx = 0;
        int  cyc = 0;
        bit  bubble = 0;
        bit  first_bubble = 1;
        bit  probe_next = 0;
        bit  xfer;
        done_cyc   = -1;
        ndone      = 0;
        load_base  = base;
        load_count = cnt;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        while (1) begin
            cyc++;
            if (cyc > 2000) begin
                chk("load_timeout", 32'(cyc), 32'(2000));
                break;
            end
            if (load_done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end else if (ndone > 0) begin
                break;
            end
            if (probe_next) begin
                chk("fetch_after_write", fetch_dout, probe_new);
                probe_next = 0;
            end
            if (bubble) begin
                chk("ready_in_write", byte_ready, 1'b0);
                if (probe && first_bubble) begin
                    chk("fetch_during_write", fetch_dout, probe_old);
                    probe_next = 1;
                end
                first_bubble = 0;
                bubble = 0;
            end
            byte_valid = (idx < nbytes) && (!gaps || ($urandom_range(0, 1) == 1));
            byte_data  = (idx < nbytes) ? stream[idx] : 8'h00;
            if (restart_mid && cyc == 3) begin
                load_start = 1'b1;
                load_base  = base + 8'd40;
                load_count = 9'd1;
            end else begin
                load_start = 1'b0;
            end
            xfer = byte_valid && byte_ready;
            tick();
            if (xfer) begin
                idx++;
                if (idx % 2 == 0) bubble = 1;
            end
        end
        byte_valid = 1'b0;
        load_start = 1'b0;
    endtask

    initial begin
        int  dc;
        int  nd;
        int  acc;
        bit  saw_done;
        rst        = 1'b1;
        fetch_add  = 8'h00;
        load_start = 1'b0;
        load_base  = 8'h00;
        load_count = 9'd0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        tick();
        tick();
        chk("rst_ready", byte_ready, 1'b0);
        chk("rst_busy",  load_busy,  1'b0);
        chk("rst_done",  load_done,  1'b0);
        rst = 1'b0;
        tick();

        // Fill the whole memory (count = DEPTH) with word i = {i, ~i}.
        for (int i = 0; i < 256; i++) begin
            stream[2*i]   = 8'(i);
            stream[2*i+1] = ~8'(i);
            model[i]      = {8'(i), ~8'(i)};
        end
        do_load(8'h00, 9'd256, 512, 0, 0, 0, 16'h0, 16'h0, dc, nd);
        chk("full_done_cnt", 32'(nd), 32'd1);
        chk_mem("full_w00", 8'h00);
        chk_mem("full_w7f", 8'h7F);
        chk_mem("full_wff", 8'hFF);

        // Combinational fetch: no clock between address change and compare.
        for (int a = 0; a < 4; a++) begin
            fetch_add = 8'(a);
            #1;
            chk("fetch_comb", fetch_dout, {8'(a), ~8'(a)});
        end

        // Basic load, also probing fetch at 0x10 across its write cycle.
        stream[0] = 8'hA1; stream[1] = 8'hB2; stream[2] = 8'hC3; stream[3] = 8'hD4;
        fetch_add = 8'h10;
        do_load(8'h10, 9'd2, 4, 0, 0, 1, 16'h10EF, 16'hA1B2, dc, nd);
        chk("basic_busy_fall", load_busy, 1'b0);
        chk("basic_done_cnt", 32'(nd), 32'd1);
        chk("basic_done_cyc", 32'(dc), 32'd7);
        model[8'h10] = 16'hA1B2;
        model[8'h11] = 16'hC3D4;
        chk_mem("basic_w10", 8'h10);
        chk_mem("basic_w11", 8'h11);
        chk_mem("basic_w12", 8'h12);

        // Wrap-around from the last word.
        stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33; stream[3] = 8'h44;
        do_load(8'hFF, 9'd2, 4, 0, 0, 0, 16'h0, 16'h0, dc, nd);
        chk("wrap_done_cnt", 32'(nd), 32'd1);
        chk("wrap_w00_exp", 32'(model[8'h01]), 32'h01FE);
        model[8'hFF] = 16'h1122;
        model[8'h00] = 16'h3344;
        chk_mem("wrap_wff", 8'hFF);
        chk_mem("wrap_w00", 8'h00);
        chk_mem("wrap_w01", 8'h01);

        // Random gaps plus an ignored second start mid-load.
        stream[0] = 8'hDE; stream[1] = 8'hAD; stream[2] = 8'hBE;
        stream[3] = 8'hEF; stream[4] = 8'h12; stream[5] = 8'h34;
        do_load(8'h20, 9'd3, 6, 1, 1, 0, 16'h0, 16'h0, dc, nd);
        chk("gap_done_cnt", 32'(nd), 32'd1);
        model[8'h20] = 16'hDEAD;
        model[8'h21] = 16'hBEEF;
        model[8'h22] = 16'h1234;
        chk_mem("gap_w20", 8'h20);
        chk_mem("gap_w21", 8'h21);
        chk_mem("gap_w22", 8'h22);
        chk_mem("gap_w23", 8'h23);
        chk_mem("gap_restart_w48", 8'h48);

        // Zero count: done on the first cycle after the start edge, nothing written.
        do_load(8'h60, 9'd0, 0, 0, 0, 0, 16'h0, 16'h0, dc, nd);
        chk("zero_done_cyc", 32'(dc), 32'd1);
        chk("zero_done_cnt", 32'(nd), 32'd1);
        chk_mem("zero_w60", 8'h60);

        // Reset after the first beat of word 2.
        load_base  = 8'h30;
        load_count = 9'd2;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        stream[0] = 8'h55; stream[1] = 8'h66; stream[2] = 8'h77;
        acc = 0;
        saw_done = 0;
        for (int c = 0; c < 50 && acc < 3; c++) begin
            byte_valid = 1'b1;
            byte_data  = stream[acc];
            if (byte_ready) begin
                tick();
                acc++;
            end else begin
                tick();
            end
        end
        chk("rst_mid_beats", 32'(acc), 32'd3);
        byte_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_ready", byte_ready, 1'b0);
        chk("rst_mid_busy",  load_busy,  1'b0);
        for (int c = 0; c < 8; c++) begin
            if (load_done) saw_done = 1;
            tick();
        end
        chk("rst_mid_nodone", saw_done, 1'b0);
        model[8'h30] = 16'h5566;
        chk_mem("rst_mid_w30", 8'h30);
        chk_mem("rst_mid_w31", 8'h31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
